// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI-Stream FIFO with tuser sideband and tlast packet tracking
//
// Purpose:
//   First-word-fall-through stream FIFO between a producer (DMA/input
//   formatter) and the accelerator core. tdata, tuser and tlast are stored
//   verbatim. With PKT_MODE=1 the output is gated until a whole packet
//   (a stored tlast beat) is held. When the FIFO fills without holding a
//   complete packet, the output opens anyway so that oversize packets drain
//   cut-through and the FIFO cannot deadlock.
//
// Parameters:
//   DATA_WIDTH  tdata width in bits (>=1)
//   USER_WIDTH  tuser width in bits (>=1)
//   DEPTH       storage entries; power of 2, >=2
//   PKT_MODE    0 = cut-through, 1 = store-and-forward on tlast
//   CW          width of the occupancy outputs, $clog2(DEPTH)+1
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   s_axis_tdata   in   input beat data
//   s_axis_tuser   in   input beat sideband
//   s_axis_tlast   in   input end-of-packet
//   s_axis_tvalid  in   input beat valid
//   s_axis_tready  out  FIFO can accept a beat (registered)
//   m_axis_tdata   out  head-of-FIFO data
//   m_axis_tuser   out  head-of-FIFO sideband
//   m_axis_tlast   out  head-of-FIFO end-of-packet
//   m_axis_tvalid  out  head beat presented
//   m_axis_tready  in   downstream accepts the beat
//   word_count     out  entries held, 0..DEPTH
//   pkt_count      out  complete packets (stored tlast beats) held

module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2,
  parameter int DEPTH      = 16,
  parameter bit PKT_MODE   = 1'b0,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [CW-1:0]         word_count,
  output logic [CW-1:0]         pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_WIDTH + USER_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry layout: {tlast, tuser, tdata}
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] word_cnt_nxt;
  logic [CW-1:0] pkt_cnt_nxt;
  logic          tready_q;

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic pkt_inc;
  logic pkt_dec;

  assign full  = (word_cnt == DEPTH_C);
  assign empty = (word_cnt == '0);

  // tready_q is already low when full, so a pop at full cannot open a push
  // in the same cycle.
  assign push = s_axis_tvalid & tready_q;
  assign pop  = m_axis_tvalid & m_axis_tready;

  // Once asserted, tvalid can only fall through a pop: pkt_cnt only
  // decrements on pop and full can only clear on pop.
  assign m_axis_tvalid = !empty && (!PKT_MODE || (pkt_cnt != '0) || full);

  assign head          = mem[rd_ptr];
  assign m_axis_tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_tuser  = head[DATA_WIDTH +: USER_WIDTH];
  assign m_axis_tlast  = head[EW-1];

  assign s_axis_tready = tready_q;
  assign word_count    = word_cnt;
  assign pkt_count     = pkt_cnt;

  assign pkt_inc = push & s_axis_tlast;
  assign pkt_dec = pop & m_axis_tlast;

  always_comb begin
    word_cnt_nxt = word_cnt;
    if (push && !pop) begin
      word_cnt_nxt = word_cnt + CW'(1);
    end else if (pop && !push) begin
      word_cnt_nxt = word_cnt - CW'(1);
    end
  end

  // Saturating decrement: the tail of an escaped oversize packet must never
  // wrap the packet count.
  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (pkt_inc && !pkt_dec) begin
      pkt_cnt_nxt = pkt_cnt + CW'(1);
    end else if (pkt_dec && !pkt_inc && (pkt_cnt != '0)) begin
      pkt_cnt_nxt = pkt_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      word_cnt <= word_cnt_nxt;
      pkt_cnt  <= pkt_cnt_nxt;
      tready_q <= (word_cnt_nxt != DEPTH_C);
    end
  end

  // Storage is not reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - scoreboard bench for axis_pkt_fifo (cut-through and packet mode)

module tb_axis_pkt_fifo;

  localparam int DW = 32;
  localparam int UW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DEPTH=16 cut-through. Index 1: DEPTH=8 packet mode.
  logic [1:0][DW-1:0] s_tdata;
  logic [1:0][UW-1:0] s_tuser;
  logic [1:0]         s_tlast;
  logic [1:0]         s_tvalid;
  logic [1:0]         s_tready;
  logic [1:0][DW-1:0] m_tdata;
  logic [1:0][UW-1:0] m_tuser;
  logic [1:0]         m_tlast;
  logic [1:0]         m_tvalid;
  logic [1:0]         m_tready;
  logic [1:0][4:0]    wc;
  logic [1:0][4:0]    pc;
  logic [3:0]         wc_pk;
  logic [3:0]         pc_pk;

  assign wc[1] = {1'b0, wc_pk};
  assign pc[1] = {1'b0, pc_pk};

  int vectors = 0;
  int errors  = 0;
  int edges;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(16), .PKT_MODE(1'b0)) dut_ct (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata[0]), .s_axis_tuser(s_tuser[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tuser(m_tuser[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .word_count(wc[0]), .pkt_count(pc[0])
  );

  axis_pkt_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(8), .PKT_MODE(1'b1)) dut_pk (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata[1]), .s_axis_tuser(s_tuser[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tuser(m_tuser[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .word_count(wc_pk), .pkt_count(pc_pk)
  );

  // Clock edges seen since reset release; s_axis_tready is only defined from the first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 3) edges <= edges + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds tvalid until accepted; called and returns at posedge+1.
  task automatic send(input int g, input logic [DW-1:0] d, input logic [UW-1:0] u, input logic l);
    int t;
    s_tdata[g]  = d;
    s_tuser[g]  = u;
    s_tlast[g]  = l;
    s_tvalid[g] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_tready[g] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready[g]) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout dut%0d: tready stayed 0, required 1", g);
      s_tvalid[g] = 1'b0;
      step();
    end else begin
      step();
      s_tvalid[g] = 1'b0;
    end
  endtask

  task automatic drain(input int g);
    int t;
    m_tready[g] = 1'b1;
    t = 0;
    @(negedge clk);
    while (wc[g] != 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("drain_wc_dut%0d", g), 64'(wc[g]), 64'd0);
    step();
  endtask

  // Per-instance scoreboard monitor: captures accepted input beats, pops and
  // compares on every output handshake, and tracks occupancy and stall rules.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int DEP = (g == 0) ? 16 : 8;
    logic [DW+UW:0] exp_q [$];
    logic [DW+UW:0] item;
    logic [DW+UW:0] prev_d;
    logic           prev_v;
    logic           prev_r;
    logic           have_prev;
    int             mwc;
    int             mpc;
    logic           exp_v;

    initial begin
      mwc = 0;
      mpc = 0;
      have_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_q.delete();
          mwc = 0;
          mpc = 0;
          have_prev = 1'b0;
        end else begin
          check($sformatf("wc_dut%0d", g), 64'(wc[g]), 64'(mwc));
          check($sformatf("pc_dut%0d", g), 64'(pc[g]), 64'(mpc));
          exp_v = (mwc != 0) && ((g == 0) || (mpc != 0) || (mwc == DEP));
          check($sformatf("tvalid_dut%0d", g), 64'(m_tvalid[g]), 64'(exp_v));
          if (edges >= 1)
            check($sformatf("tready_dut%0d", g), 64'(s_tready[g]), 64'(mwc != DEP));
          if (have_prev && prev_v && !prev_r)
            check($sformatf("stall_hold_dut%0d", g),
                  {28'd0, m_tvalid[g], m_tlast[g], m_tuser[g], m_tdata[g]}, {28'd0, 1'b1, prev_d});
          if (m_tvalid[g] && m_tready[g]) begin
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL pop_empty_dut%0d: pop with no expected beat, data %0h", g, m_tdata[g]);
            end else begin
              item = exp_q.pop_front();
              check($sformatf("beat_dut%0d", g),
                    64'({m_tlast[g], m_tuser[g], m_tdata[g]}), 64'(item));
              mwc--;
              if (item[DW+UW] && mpc != 0) mpc--;
            end
          end
          if (s_tvalid[g] && s_tready[g]) begin
            exp_q.push_back({s_tlast[g], s_tuser[g], s_tdata[g]});
            mwc++;
            if (s_tlast[g]) mpc++;
          end
          prev_v    = m_tvalid[g];
          prev_r    = m_tready[g];
          prev_d    = {m_tlast[g], m_tuser[g], m_tdata[g]};
          have_prev = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  logic rnd_done;

  initial begin
    s_tdata = '0; s_tuser = '0; s_tlast = '0; s_tvalid = '0; m_tready = '0;
    rnd_done = 1'b0;

    // Reset state
    #12;
    check("rst_tready0", 64'(s_tready[0]), 64'd0);
    check("rst_tready1", 64'(s_tready[1]), 64'd0);
    check("rst_tvalid0", 64'(m_tvalid[0]), 64'd0);
    check("rst_wc0", 64'(wc[0]), 64'd0);
    check("rst_pc1", 64'(pc[1]), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready_before_edge", 64'(s_tready[0]), 64'd0);
    @(negedge clk);
    check("rel_tready_after_edge", 64'(s_tready[0]), 64'd1);
    step();

    // 1: three beats, one cycle latency, tlast on 0x33
    m_tready[0] = 1'b1;
    send(0, 32'h11, 2'd1, 1'b0);
    @(negedge clk);
    check("t1_lat_v", 64'(m_tvalid[0]), 64'd1);
    check("t1_lat_d", 64'(m_tdata[0]), 64'h11);
    step();
    send(0, 32'h22, 2'd2, 1'b0);
    @(negedge clk);
    check("t1_lat_d2", 64'(m_tdata[0]), 64'h22);
    step();
    send(0, 32'h33, 2'd3, 1'b1);
    @(negedge clk);
    check("t1_d3", 64'({m_tlast[0], m_tdata[0]}), {31'd0, 1'b1, 32'h33});
    step();
    drain(0);
    check("t1_pc", 64'(pc[0]), 64'd0);

    // 2: fill DEPTH=16, 17th beat waits for a pop
    m_tready[0] = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 32'h100 + i, UW'(i), 1'b0);
    @(negedge clk);
    check("t2_full_tready", 64'(s_tready[0]), 64'd0);
    check("t2_full_wc", 64'(wc[0]), 64'd16);
    step();
    s_tdata[0] = 32'h1FF; s_tuser[0] = 2'd3; s_tlast[0] = 1'b1; s_tvalid[0] = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("t2_blocked_wc", 64'(wc[0]), 64'd16);
    step();
    m_tready[0] = 1'b1;
    step();
    m_tready[0] = 1'b0;
    @(negedge clk);
    check("t2_pop_tready", 64'(s_tready[0]), 64'd1);
    check("t2_pop_wc", 64'(wc[0]), 64'd15);
    step();
    s_tvalid[0] = 1'b0;
    @(negedge clk);
    check("t2_17th_wc", 64'(wc[0]), 64'd16);
    step();
    drain(0);

    // 3: store-and-forward gating on a 4-beat packet
    m_tready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1, 32'hA0 + i, UW'(i), 1'b0);
      @(negedge clk);
      check("t3_gated", 64'(m_tvalid[1]), 64'd0);
      step();
    end
    send(1, 32'hA3, 2'd3, 1'b1);
    @(negedge clk);
    check("t3_open", 64'(m_tvalid[1]), 64'd1);
    check("t3_pc", 64'(pc[1]), 64'd1);
    check("t3_head", 64'(m_tdata[1]), 64'hA0);
    step();
    drain(1);
    check("t3_pc_end", 64'(pc[1]), 64'd0);

    // 4: 12-beat packet through DEPTH=8 via the full escape
    m_tready[1] = 1'b0;
    for (int i = 0; i < 8; i++) send(1, 32'hC00 + i, UW'(i), 1'b0);
    @(negedge clk);
    check("t4_escape_v", 64'(m_tvalid[1]), 64'd1);
    check("t4_escape_wc", 64'(wc[1]), 64'd8);
    check("t4_escape_pc", 64'(pc[1]), 64'd0);
    step();
    m_tready[1] = 1'b1;
    for (int i = 8; i < 12; i++) send(1, 32'hC00 + i, UW'(i), i == 11);
    drain(1);
    check("t4_pc_end", 64'(pc[1]), 64'd0);

    // 5: random valid/ready and tuser, 1000 beats
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 1)) step();
          send(0, $urandom, UW'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_tready[0] = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain(0);

    // 6: async reset with 5 beats of a partial packet stored
    m_tready[0] = 1'b0;
    for (int i = 0; i < 5; i++) send(0, 32'hD0 + i, UW'(i), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", 64'(m_tvalid[0]), 64'd0);
    check("t6_async_wc", 64'(wc[0]), 64'd0);
    check("t6_async_pc", 64'(pc[0]), 64'd0);
    check("t6_async_tready", 64'(s_tready[0]), 64'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_tready_pre", 64'(s_tready[0]), 64'd0);
    @(negedge clk);
    check("t6_tready_post", 64'(s_tready[0]), 64'd1);
    step();
    m_tready[0] = 1'b1;
    send(0, 32'hE1, 2'd1, 1'b0);
    send(0, 32'hE2, 2'd2, 1'b0);
    send(0, 32'hE3, 2'd3, 1'b1);
    drain(0);
    check("t6_pc_end", 64'(pc[0]), 64'd0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
